// File: rtl/wash_ctrl.sv
// wash_ctrl: washing-machine program controller.
//
// Runs the selected program through WASH, RINSES rinse passes and SPIN,
// then waits in DONE until the next start. All outputs are registered.
//
// Parameters
//   TICK_DIV : clk cycles per second (divisible by LEVEL_W, >= 2*LEVEL_W)
//   RINSES   : rinse passes per program, 1..2
//   LEVEL_W  : width of the water-level thermometer bar
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   on       in   machine enable; low freezes everything and ignores buttons
//   start    in   one-cycle pulse: begin a run from IDLE, or leave DONE
//   pause    in   one-cycle pulse: toggle pause while WASH/RINSE/SPIN
//   mode     in   program select, latched on an accepted start
//   phase    out  0 IDLE, 1 WASH, 2 RINSE, 3 SPIN, 4 DONE (the FSM state)
//   action   out  per-second action code for the display
//   rem_tens out  BCD tens digit of remaining seconds
//   rem_ones out  BCD ones digit of remaining seconds
//   level    out  water-level thermometer code, LSB-first fill
//   paused   out  high while paused
//   done     out  high in DONE
//
// start and pause are single-cycle pulses from the debouncers; there is no
// handshake back, and a pulse arriving while it cannot act is simply dropped.
module wash_ctrl #(
    parameter int TICK_DIV = 100_000_000,
    parameter int RINSES   = 1,
    parameter int LEVEL_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               on,
    input  logic               start,
    input  logic               pause,
    input  logic [1:0]         mode,
    output logic [2:0]         phase,
    output logic [3:0]         action,
    output logic [3:0]         rem_tens,
    output logic [3:0]         rem_ones,
    output logic [LEVEL_W-1:0] level,
    output logic               paused,
    output logic               done
);

    localparam logic [2:0] P_IDLE  = 3'd0;
    localparam logic [2:0] P_WASH  = 3'd1;
    localparam logic [2:0] P_RINSE = 3'd2;
    localparam logic [2:0] P_SPIN  = 3'd3;
    localparam logic [2:0] P_DONE  = 3'd4;

    localparam logic [3:0] A_IDLE  = 4'd0;
    localparam logic [3:0] A_ROT   = 4'd1;
    localparam logic [3:0] A_STEW  = 4'd2;
    localparam logic [3:0] A_FILL  = 4'd3;
    localparam logic [3:0] A_DRAIN = 4'd4;
    localparam logic [3:0] A_FWD   = 4'd5;
    localparam logic [3:0] A_REV   = 4'd6;
    localparam logic [3:0] A_DONE  = 4'd10;

    localparam int STEP   = TICK_DIV / LEVEL_W;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;

    logic [1:0]        mode_q;
    logic [TICK_W-1:0] tick_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic [4:0]        ps;
    logic [1:0]        pass_cnt;

    logic [2:0]        phase_n;
    logic [4:0]        ps_n;
    logic [1:0]        pass_n;
    logic [TICK_W-1:0] tick_n;
    logic [3:0]        tens_n;
    logic [3:0]        ones_n;
    logic [3:0]        action_n;
    logic              paused_n;
    logic              done_n;
    logic [1:0]        mode_n;
    logic              clr_level;
    logic              running;
    logic [7:0]        total_bcd;

    // Every phase of a program lasts the same number of seconds, except
    // mode 0 which only spins.
    function automatic logic [4:0] phase_secs(input logic [1:0] m);
        case (m)
            2'd0:    return 5'd15;
            2'd1:    return 5'd10;
            2'd2:    return 5'd15;
            default: return 5'd20;
        endcase
    endfunction

    // Total run time of a program, returned as two BCD digits {tens, ones}.
    function automatic logic [7:0] total_of(input logic [1:0] m);
        logic [6:0] t;
        logic [3:0] tens;
        if (m == 2'd0) t = 7'd15;
        else           t = 7'(int'(phase_secs(m)) * (RINSES + 2));
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (t >= 7'd10) begin
                t    = t - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, t[3:0]};
    endfunction

    function automatic logic [3:0] action_of(input logic [2:0] ph,
                                             input logic [4:0] s);
        case (ph)
            P_WASH:  return s[0] ? A_STEW : A_ROT;
            P_RINSE: begin
                case (s % 5'd3)
                    5'd0:    return A_FILL;
                    5'd1:    return A_ROT;
                    default: return A_DRAIN;
                endcase
            end
            P_SPIN: begin
                case (s[1:0])
                    2'd0:    return A_FWD;
                    2'd2:    return A_REV;
                    default: return A_DRAIN;
                endcase
            end
            P_DONE:  return A_DONE;
            default: return A_IDLE;
        endcase
    endfunction

    always_comb begin
        phase_n   = phase;
        ps_n      = ps;
        pass_n    = pass_cnt;
        tick_n    = tick_cnt;
        tens_n    = rem_tens;
        ones_n    = rem_ones;
        paused_n  = paused;
        done_n    = done;
        mode_n    = mode_q;
        clr_level = 1'b0;
        total_bcd = total_of(mode);
        running   = on && !paused &&
                    (phase == P_WASH || phase == P_RINSE || phase == P_SPIN);

        if (on) begin
            case (phase)
                P_IDLE: begin
                    if (start) begin
                        mode_n  = mode;
                        tens_n  = total_bcd[7:4];
                        ones_n  = total_bcd[3:0];
                        tick_n  = '0;
                        ps_n    = 5'd0;
                        pass_n  = 2'd1;
                        phase_n = (mode == 2'd0) ? P_SPIN : P_WASH;
                    end
                end
                P_DONE: begin
                    if (start) begin
                        phase_n   = P_IDLE;
                        tens_n    = 4'd0;
                        ones_n    = 4'd0;
                        done_n    = 1'b0;
                        clr_level = 1'b1;
                    end
                end
                P_WASH, P_RINSE, P_SPIN: begin
                    if (!paused) begin
                        if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
                            tick_n = '0;
                            // BCD countdown with borrow, saturating at 00.
                            if (rem_ones != 4'd0) begin
                                ones_n = rem_ones - 4'd1;
                            end else if (rem_tens != 4'd0) begin
                                tens_n = rem_tens - 4'd1;
                                ones_n = 4'd9;
                            end
                            if (ps + 5'd1 == phase_secs(mode_q)) begin
                                ps_n = 5'd0;
                                case (phase)
                                    P_WASH: begin
                                        phase_n = P_RINSE;
                                        pass_n  = 2'd1;
                                    end
                                    P_RINSE: begin
                                        if (pass_cnt == 2'(RINSES)) phase_n = P_SPIN;
                                        else                        pass_n  = pass_cnt + 2'd1;
                                    end
                                    default: begin
                                        phase_n = P_DONE;
                                        tens_n  = 4'd0;
                                        ones_n  = 4'd0;
                                        done_n  = 1'b1;
                                    end
                                endcase
                            end else begin
                                ps_n = ps + 5'd1;
                            end
                        end else begin
                            tick_n = tick_cnt + TICK_W'(1);
                        end
                    end
                    if (pause) paused_n = !paused;
                    // A pause landing on the final tick is dropped: DONE is never paused.
                    if (phase_n == P_DONE) paused_n = 1'b0;
                end
                default: phase_n = P_IDLE;
            endcase
        end

        action_n = action_of(phase_n, ps_n);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    <= P_IDLE;
            action   <= A_IDLE;
            rem_tens <= 4'd0;
            rem_ones <= 4'd0;
            level    <= '0;
            paused   <= 1'b0;
            done     <= 1'b0;
            mode_q   <= 2'd3;
            tick_cnt <= '0;
            step_cnt <= '0;
            ps       <= 5'd0;
            pass_cnt <= 2'd1;
        end else begin
            phase    <= phase_n;
            action   <= action_n;
            rem_tens <= tens_n;
            rem_ones <= ones_n;
            paused   <= paused_n;
            done     <= done_n;
            mode_q   <= mode_n;
            tick_cnt <= tick_n;
            ps       <= ps_n;
            pass_cnt <= pass_n;

            // Level steps on the last cycle of each STEP-long slot of the
            // current action, so a full fill/drain completes within one
            // second, including the step on the edge where the action ends.
            if (running) begin
                if (step_cnt == STEP_W'(STEP - 1)) begin
                    step_cnt <= '0;
                    if (action == A_FILL)  level <= {level[LEVEL_W-2:0], 1'b1};
                    if (action == A_DRAIN) level <= {1'b0, level[LEVEL_W-1:1]};
                end else begin
                    step_cnt <= step_cnt + STEP_W'(1);
                end
            end
            if (action_n != action) step_cnt <= '0;
            if (phase_n == P_WASH)  level    <= '1;
            if (clr_level)          level    <= '0;
        end
    end

endmodule
